// File: rtl/avg_sum_decoder.sv
// avg_sum_decoder: inverts an 8-tap running sum of unsigned 8-bit samples,
// recovering the newest sample each time a new window sum is accepted.
//
// Ports:
//   clk        rising-edge clock
//   rs         asynchronous active-high reset
//   sum_in     running sum of the last 8 samples (11 b)
//   sum_valid  sum_in carries a new window sum this cycle
//   sum_ready  block can accept sum_in this cycle (combinational)
//   x_out      recovered newest sample (8 b)
//   x_valid    x_out holds an unconsumed sample
//   x_ready    downstream accepts x_out this cycle
//   err        sticky flag: a recovered value fell outside 0..255
module avg_sum_decoder (
   input  logic        clk,
   input  logic        rs,
   input  logic [10:0] sum_in,
   input  logic        sum_valid,
   output logic        sum_ready,
   output logic [7:0]  x_out,
   output logic        x_valid,
   input  logic        x_ready,
   output logic        err
);

   localparam int unsigned SUM_W = 11;
   localparam int unsigned X_W   = 8;
   localparam int unsigned D_W   = 12;
   localparam int unsigned DEPTH = 8;

   logic [SUM_W-1:0]            prev_sum;
   logic [DEPTH-1:0][X_W-1:0]   hist;      // hist[0] newest, hist[DEPTH-1] = x[n-8]
   logic                        accept;
   logic [D_W-1:0]              d;
   logic                        d_bad;

   // Upstream may push whenever the output slot is free or being drained.
   assign sum_ready = !x_valid || x_ready;
   assign accept    = sum_valid && sum_ready;

   // x[n] = sum[n] - sum[n-1] + x[n-8], evaluated in 12-bit two's complement.
   assign d = D_W'(sum_in) - D_W'(prev_sum) + D_W'(hist[DEPTH-1]);

   // Out of range when negative or above 255; any wrapped overflow of an
   // illegal sum lands in the negative half, so it is still caught.
   assign d_bad = d[D_W-1] || (d[D_W-2:X_W] != '0);

   // Decoder state, output register and handshake.
   always_ff @(posedge clk or posedge rs) begin
      if (rs) begin
         x_out    <= '0;
         x_valid  <= 1'b0;
         err      <= 1'b0;
         prev_sum <= '0;
         hist     <= '0;
      end else begin
         if (accept) begin
            x_out    <= d[X_W-1:0];
            x_valid  <= 1'b1;
            prev_sum <= sum_in;
            hist     <= {hist[DEPTH-2:0], d[X_W-1:0]};
            if (d_bad) begin
               err <= 1'b1;
            end
         end else if (x_ready) begin
            x_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_avg_sum_decoder.sv
// tb_avg_sum_decoder: randomized and directed checks of avg_sum_decoder
// against a sample-level model of an 8-tap running-sum source.
module tb_avg_sum_decoder;

   logic        clk;
   logic        rs;
   logic [10:0] sum_in;
   logic        sum_valid;
   logic        sum_ready;
   logic [7:0]  x_out;
   logic        x_valid;
   logic        x_ready;
   logic        err;

   int check_cnt;
   int pass_cnt;
   int src_q[$];   // source samples since the last reset

   avg_sum_decoder dut (
      .clk       (clk),
      .rs        (rs),
      .sum_in    (sum_in),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .x_out     (x_out),
      .x_valid   (x_valid),
      .x_ready   (x_ready),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   // Window sum the source would emit after appending its newest sample.
   function automatic int window_sum();
      int s = 0;
      int n = src_q.size();
      for (int i = 0; i < 8; i++) begin
         if (n - 1 - i >= 0) s += src_q[n - 1 - i];
      end
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rs        = 1'b1;
      sum_valid = 1'b0;
      sum_in    = '0;
      x_ready   = 1'b1;
      @(posedge clk);
      #1;
      check("rst_x_valid", 32'(x_valid), 0);
      check("rst_x_out", 32'(x_out), 0);
      check("rst_err", 32'(err), 0);
      check("rst_sum_ready", 32'(sum_ready), 1);
      @(negedge clk);
      rs = 1'b0;
      src_q.delete();
   endtask

   // Source emits one new sample; the decoder output after the edge must match it.
   task automatic push_sample(input int x, input string tag);
      src_q.push_back(x);
      @(negedge clk);
      sum_in    = 11'(window_sum());
      sum_valid = 1'b1;
      x_ready   = 1'b1;
      @(posedge clk);
      #1;
      check(tag, 32'(x_out), 32'(x));
      check({tag, "_v"}, 32'(x_valid), 1);
   endtask

   task automatic go_idle();
      @(negedge clk);
      sum_valid = 1'b0;
      @(posedge clk);
      #1;
      check("idle_drain", 32'(x_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      check_cnt = 0;
      pass_cnt  = 0;
      rs        = 1'b1;
      sum_valid = 1'b0;
      sum_in    = '0;
      x_ready   = 1'b1;

      // Three-sample basic decode: sums 10, 30, 60.
      do_reset();
      push_sample(10, "basic0");
      push_sample(20, "basic1");
      push_sample(30, "basic2");
      check("basic_err", 32'(err), 0);
      go_idle();

      // Samples 1..12 exercise the x[n-8] add-back from the 9th on.
      do_reset();
      for (int i = 1; i <= 12; i++) push_sample(i, $sformatf("ramp%0d", i));

      // Backpressure: pending 12 must hold while sum 13 waits.
      src_q.push_back(13);
      @(negedge clk);
      sum_in    = 11'(window_sum());
      sum_valid = 1'b1;
      x_ready   = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("bp_ready", 32'(sum_ready), 0);
         check("bp_x_out", 32'(x_out), 12);
         check("bp_x_valid", 32'(x_valid), 1);
      end
      @(negedge clk);
      x_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", 32'(x_out), 13);
      for (int i = 14; i <= 20; i++) push_sample(i, $sformatf("post_bp%0d", i));
      check("bp_err", 32'(err), 0);
      go_idle();

      // Out-of-range: 300 decodes to 44 and sets err; 250 gives d=-50.
      do_reset();
      @(negedge clk);
      sum_in    = 11'd300;
      sum_valid = 1'b1;
      @(posedge clk);
      #1;
      check("ovf_x_out", 32'(x_out), 44);
      check("ovf_err", 32'(err), 1);
      @(negedge clk);
      sum_in = 11'd250;
      @(posedge clk);
      #1;
      check("neg_x_out", 32'(x_out), 206);
      check("neg_err_sticky", 32'(err), 1);
      go_idle();
      check("err_stays", 32'(err), 1);

      // Asynchronous reset while a sample is pending and err is set.
      do_reset();
      @(negedge clk);
      sum_in    = 11'd300;
      sum_valid = 1'b1;
      @(posedge clk);
      #1;
      check("pre_ar_valid", 32'(x_valid), 1);
      check("pre_ar_err", 32'(err), 1);
      @(negedge clk);
      sum_valid = 1'b0;
      x_ready   = 1'b0;
      #2;
      rs = 1'b1;
      #1;
      check("ar_x_valid", 32'(x_valid), 0);
      check("ar_x_out", 32'(x_out), 0);
      check("ar_err", 32'(err), 0);
      @(negedge clk);
      rs = 1'b0;
      src_q.delete();
      push_sample(7, "after_ar");
      check("after_ar_err", 32'(err), 0);
      go_idle();

      // 64 random legal samples at full throughput.
      do_reset();
      for (int i = 0; i < 64; i++) begin
         push_sample(int'($urandom_range(0, 255)), $sformatf("rand%0d", i));
      end
      check("rand_err", 32'(err), 0);
      go_idle();

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
